// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the unified-memory arbiter: owner encodings and port widths.
// Latency: none (package only). Backpressure: n/a.
// Owner codes tag the cycle-N grant so the cycle-N+1 response is routed correctly.
package mem_arbiter_pkg;

    localparam logic [1:0] MEM_OWN_NONE = 2'd0;
    localparam logic [1:0] MEM_OWN_IF   = 2'd1;
    localparam logic [1:0] MEM_OWN_DR   = 2'd2;
    localparam logic [1:0] MEM_OWN_DW   = 2'd3;

    localparam int MEM_ADDR_WIDTH = 32;
    localparam int MEM_DATA_WIDTH = 32;
    localparam int MEM_BE_WIDTH   = MEM_DATA_WIDTH / 8;

    function automatic logic [1:0] mem_own_sel(input logic if_gnt,
                                               input logic d_gnt,
                                               input logic d_we);
        logic [1:0] own;
        own = MEM_OWN_NONE;
        if (d_gnt)
            own = d_we ? MEM_OWN_DW : MEM_OWN_DR;
        else if (if_gnt)
            own = MEM_OWN_IF;
        return own;
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Grant policy for fetch vs data; MEM_ARB_ROUND_ROBIN_EN selects round-robin, else data-over-fetch.
// Latency: combinational grant. Backpressure: loser sees gnt=0 and must hold its request.
// Grants are forced low while rst_n is low.
module mem_arb_grant (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic clk,
`endif
    input  logic rst_n,
    input  logic if_req,
    input  logic d_req,
    output logic if_gnt,
    output logic d_gnt
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // rr_q holds the last conflict winner: 0 = fetch, 1 = data
    logic rr_q;
    logic rr_d;
    logic conflict;

    always_comb begin
        conflict = if_req & d_req;
        rr_d     = rr_q;
        if_gnt   = 1'b0;
        d_gnt    = 1'b0;
        if (rst_n) begin
            if (conflict) begin
                d_gnt  = ~rr_q;
                if_gnt = rr_q;
                rr_d   = ~rr_q;
            end else begin
                d_gnt  = d_req;
                if_gnt = if_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_q <= 1'b0;
        else
            rr_q <= rr_d;
    end
`else
    assign d_gnt  = rst_n & d_req;
    assign if_gnt = rst_n & if_req & ~d_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one BRAM port between fetch and data; policy via MEM_ARB_ROUND_ROBIN_EN (see mem_arb_grant).
// Latency: combinational grant, response (rvalid/rdata) one cycle after grant; one access per cycle.
// Backpressure: a requester without gnt holds req/addr; fetch loss raises stall.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdat,
    output logic                    mem_wenb,
    output logic [DATA_WIDTH/8-1:0] mem_byte_enb,
    output logic                    mem_renb,
    input  logic [DATA_WIDTH-1:0]   mem_rdat,
    output logic                    stall
);

    logic [1:0]            own_q;
    logic [1:0]            own_d;
    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q;
    logic [DATA_WIDTH-1:0] d_rdata_d;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

    mem_arb_grant u_grant (
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .clk    (clk),
`endif
        .rst_n  (rst),
        .if_req (if_req),
        .d_req  (d_req),
        .if_gnt (if_gnt),
        .d_gnt  (d_gnt)
    );

    assign stall = if_req & ~if_gnt;

    always_comb begin
        mem_addr     = '0;
        mem_wdat     = '0;
        mem_wenb     = 1'b0;
        mem_renb     = 1'b0;
        mem_byte_enb = '0;
        if (d_gnt) begin
            mem_addr     = {d_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdat     = d_wdata;
            mem_wenb     = d_we;
            mem_renb     = ~d_we;
            mem_byte_enb = d_we ? d_be : '0;
        end else if (if_gnt) begin
            mem_addr = {if_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_renb = 1'b1;
        end
    end

    // rdata outputs bypass the hold register in the rvalid cycle so data and rvalid coincide
    always_comb begin
        own_d      = mem_own_sel(if_gnt, d_gnt, d_we);
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if (own_q == MEM_OWN_IF)
            if_rdata_d = mem_rdat;
        if (own_q == MEM_OWN_DR)
            d_rdata_d = mem_rdat;
        else if (own_q == MEM_OWN_DW)
            d_rdata_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            own_q      <= MEM_OWN_NONE;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            own_q      <= own_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign if_rvalid = (own_q == MEM_OWN_IF);
    assign d_rvalid  = (own_q == MEM_OWN_DR) || (own_q == MEM_OWN_DW);
    assign if_rdata  = if_rdata_d;
    assign d_rdata   = d_rdata_d;

endmodule
